// File: rtl/cache_nway_pkg.sv
// Shared types and width helpers for the N-way set-associative cache.
// The state enum and the address-split helpers live here.
package cache_nway_pkg;

    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        CHECK     = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } state_e;

    function automatic int tag_width(input int s_offset, input int s_index);
        return ADDR_W - s_offset - s_index;
    endfunction

    function automatic int line_bits(input int s_offset);
        return 8 << s_offset;
    endfunction

endpackage

// File: rtl/cache_nway_plru.sv
// Combinational tree pseudo-LRU: node i has children 2i+1 / 2i+2, leaves are ways in order.
// Produces the updated bits for an access to way_i and the victim for the current bits.
module plru_tree #(
    parameter int NUM_WAYS = 4
) (
    input  logic [NUM_WAYS-2:0]         bits_i,
    input  logic [$clog2(NUM_WAYS)-1:0] way_i,
    output logic [NUM_WAYS-2:0]         bits_o,
    output logic [$clog2(NUM_WAYS)-1:0] victim_o
);

    localparam int S_WAY = $clog2(NUM_WAYS);

    logic [S_WAY-1:0] upd_node;
    logic [S_WAY-1:0] vic_node;
    logic [S_WAY-1:0] way_sh;
    logic             dir;
    logic             bit_val;

    // NOTE: every variable written here gets a default first, so no path leaves
    // a value held over from the previous evaluation (which would infer a latch).
    always_comb begin
        bits_o   = bits_i;
        upd_node = '0;
        way_sh   = way_i;
        dir      = 1'b0;
        // Each node on the path points away from the accessed way.
        for (int l = 0; l < S_WAY; l++) begin
            dir              = way_sh[S_WAY-1];
            bits_o[upd_node] = ~dir;
            upd_node         = S_WAY'(2 * int'(upd_node) + 1 + int'(dir));
            way_sh           = way_sh << 1;
        end
    end

    always_comb begin
        victim_o = '0;
        vic_node = '0;
        bit_val  = 1'b0;
        for (int l = 0; l < S_WAY; l++) begin
            bit_val  = bits_i[vic_node];
            victim_o = S_WAY'({victim_o, bit_val});
            vic_node = S_WAY'(2 * int'(vic_node) + 1 + int'(bit_val));
        end
    end

endmodule

// File: rtl/cache_nway.sv
// N-way set-associative write-back / write-allocate cache with flop storage,
// integrated CHECK/WRITEBACK/FILL control and tree pseudo-LRU replacement.
module cache_nway
    import cache_nway_pkg::*;
#(
    parameter int S_OFFSET = 5,
    parameter int S_INDEX  = 3,
    parameter int NUM_WAYS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [31:0]                  mem_address,
    input  logic                         mem_read,
    input  logic                         mem_write,
    input  logic [(8<<S_OFFSET)-1:0]     mem_wdata256,
    input  logic [(1<<S_OFFSET)-1:0]     mem_byte_enable256,
    output logic [(8<<S_OFFSET)-1:0]     mem_rdata256,
    output logic                         mem_resp,
    output logic [31:0]                  pmem_address,
    output logic [(8<<S_OFFSET)-1:0]     pmem_wdata,
    input  logic [(8<<S_OFFSET)-1:0]     pmem_rdata,
    output logic                         pmem_read,
    output logic                         pmem_write,
    input  logic                         pmem_resp
);

    localparam int S_TAG    = tag_width(S_OFFSET, S_INDEX);
    localparam int S_LINE   = line_bits(S_OFFSET);
    localparam int S_MASK   = S_LINE / 8;
    localparam int NUM_SETS = 1 << S_INDEX;
    localparam int S_WAY    = $clog2(NUM_WAYS);

    logic [NUM_WAYS-1:0] valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0] dirty_q [NUM_SETS];
    logic [S_TAG-1:0]    tag_q   [NUM_SETS][NUM_WAYS];
    logic [S_LINE-1:0]   data_q  [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-2:0] plru_q  [NUM_SETS];

    state_e           state_q, state_d;
    logic [S_WAY-1:0] victim_q, victim_d;

    logic [S_INDEX-1:0]  idx;
    logic [S_TAG-1:0]    req_tag;
    logic                unused_offset;
    logic                hit;
    logic [S_WAY-1:0]    hit_way;
    logic                any_invalid;
    logic [S_WAY-1:0]    first_invalid;
    logic [S_WAY-1:0]    victim_sel;
    logic [S_WAY-1:0]    access_way;
    logic [S_WAY-1:0]    plru_victim;
    logic [NUM_WAYS-2:0] plru_next;
    logic [S_LINE-1:0]   merged_line;
    logic                hit_upd;
    logic                hit_wr;
    logic                fill_we;

    assign idx           = mem_address[S_OFFSET +: S_INDEX];
    assign req_tag       = mem_address[ADDR_W-1 -: S_TAG];
    assign unused_offset = ^mem_address[S_OFFSET-1:0];

    // Descending scan so the lowest matching / lowest invalid way wins.
    always_comb begin
        hit           = 1'b0;
        hit_way       = '0;
        any_invalid   = 1'b0;
        first_invalid = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (valid_q[idx][w] && tag_q[idx][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = S_WAY'(w);
            end
            if (!valid_q[idx][w]) begin
                any_invalid   = 1'b1;
                first_invalid = S_WAY'(w);
            end
        end
    end

    assign victim_sel = any_invalid ? first_invalid : plru_victim;
    assign access_way = (state_q == FILL) ? victim_q : hit_way;

    plru_tree #(
        .NUM_WAYS (NUM_WAYS)
    ) u_plru (
        .bits_i   (plru_q[idx]),
        .way_i    (access_way),
        .bits_o   (plru_next),
        .victim_o (plru_victim)
    );

    always_comb begin
        merged_line = data_q[idx][hit_way];
        for (int b = 0; b < S_MASK; b++) begin
            if (mem_byte_enable256[b]) begin
                merged_line[b*8 +: 8] = mem_wdata256[b*8 +: 8];
            end
        end
    end

    assign mem_rdata256 = data_q[idx][hit_way];
    assign pmem_wdata   = data_q[idx][victim_q];

    always_comb begin
        state_d      = state_q;
        victim_d     = victim_q;
        mem_resp     = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = {mem_address[ADDR_W-1:S_OFFSET], {S_OFFSET{1'b0}}};
        hit_upd      = 1'b0;
        hit_wr       = 1'b0;
        fill_we      = 1'b0;
        case (state_q)
            CHECK: begin
                if (mem_read || mem_write) begin
                    if (hit) begin
                        mem_resp = 1'b1;
                        hit_upd  = 1'b1;
                        hit_wr   = mem_write;
                    end else begin
                        victim_d = victim_sel;
                        state_d  = (valid_q[idx][victim_sel] && dirty_q[idx][victim_sel])
                                 ? WRITEBACK : FILL;
                    end
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_q[idx][victim_q], idx, {S_OFFSET{1'b0}}};
                if (pmem_resp) state_d = FILL;
            end
            FILL: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    fill_we = 1'b1;
                    state_d = CHECK;
                end
            end
            default: state_d = CHECK;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= CHECK;
            victim_q <= '0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
        end
    end

    // NOTE: the storage arrays are reset too, because a reset must invalidate
    // every line and restart the PLRU from all-zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                plru_q[s]  <= '0;
                for (int w = 0; w < NUM_WAYS; w++) begin
                    tag_q[s][w]  <= '0;
                    data_q[s][w] <= '0;
                end
            end
        end else begin
            if (hit_upd || fill_we) plru_q[idx] <= plru_next;
            if (hit_wr) begin
                data_q[idx][hit_way]  <= merged_line;
                dirty_q[idx][hit_way] <= 1'b1;
            end
            if (fill_we) begin
                data_q[idx][victim_q]  <= pmem_rdata;
                tag_q[idx][victim_q]   <= req_tag;
                valid_q[idx][victim_q] <= 1'b1;
                dirty_q[idx][victim_q] <= 1'b0;
            end
        end
    end

endmodule
